eight_bit_int_sqrt_engine: RTL

Sequential integer square-root engine for the 8-bit square-root finder datapath.
- Takes an unsigned radicand and computes floor(sqrt) and remainder with the digit-by-digit (restoring) method, one root bit per clock.
- Root output is zero-extended to radicand width so it drives the binary-to-BCD display converter directly, with no glue.
- Start/done handshake; results held until the next accepted start.

---
 rtl/eight_bit_int_sqrt_engine.sv | 118 +++++++++++
 1 files changed

// File: rtl/eight_bit_int_sqrt_engine.sv
// Sequential restoring square-root engine: one root bit per clock, start/done handshake.
// Root is zero-extended to radicand width; remainder = radicand - root*root.
module eight_bit_int_sqrt_engine #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   root,
    output logic [WIDTH/2:0]   remainder
);

    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 2;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;

    // Handshake: start is accepted on any rising edge where ready=1; done pulses for
    // exactly one cycle and root/remainder stay valid until the next accepted start.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  rad_q,   rad_d;
    logic [HW-1:0]     q_q,     q_d;
    logic [RW-1:0]     r_q,     r_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]  root_q,  root_d;
    logic [HW:0]       rem_q,   rem_d;

    logic [RW+1:0]     r_shift;
    logic [RW+1:0]     trial;
    logic              ge;
    logic [RW-1:0]     r_iter;
    logic [HW-1:0]     q_iter;

    // One restoring step: the radicand shift register always presents the next
    // bit pair at its top, so no indexed select by the counter is needed.
    always_comb begin
        r_shift = {r_q, rad_q[WIDTH-1 -: 2]};
        trial   = {2'b00, q_q, 2'b01};
        ge      = (r_shift >= trial);
        r_iter  = ge ? RW'(r_shift - trial) : RW'(r_shift);
        q_iter  = {q_q[HW-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rad_d   = radicand;
                    q_d     = '0;
                    r_d     = '0;
                    cnt_d   = CW'(HW - 1);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                rad_d = {rad_q[WIDTH-3:0], 2'b00};
                q_d   = q_iter;
                r_d   = r_iter;
                if (cnt_q == '0) begin
                    root_d  = {{(WIDTH-HW){1'b0}}, q_iter};
                    rem_d   = (HW+1)'(r_iter);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rad_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CALC);
    assign done      = (state_q == ST_DONE);
    assign root      = root_q;
    assign remainder = rem_q;

endmodule
